// File: rtl/chunk_pkg.sv
// chunk_pkg: width rules shared by chunker and dechunker so both ends of the
// narrow link agree on chunk count and counter width.
//   cnt_w(nr)             : counter width for nr chunks per word, minimum 1 bit.
//   `CHUNK_WIDTH_CHECK    : elaboration guard; L must be a multiple of M, M < L.

`ifndef CHUNK_PKG_SV
`define CHUNK_PKG_SV

// Used inside a module body. It expands to a generate-if that stops elaboration
// on a bad L/M pair.
`define CHUNK_WIDTH_CHECK(LL, MM) \
  if ((((LL) % (MM)) != 0) || ((MM) >= (LL))) begin : g_bad_chunk_width \
    $error("chunk widths invalid: L must be a multiple of M and M < L"); \
  end

package chunk_pkg;

  function automatic int cnt_w(int nr);
    return (nr <= 2) ? 1 : $clog2(nr);
  endfunction

endpackage

`endif

// File: rtl/dechunker.sv
// dechunker: reassembles M-bit chunks, MSB chunk first, into L-bit words.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears q, strobe, busy and all state
//   d      : incoming chunk, used only when valid=1
//   valid  : d carries a chunk this cycle
//   align  : drop any partial word; a chunk presented on the same edge is
//            taken as chunk 0 of a new word
//   q      : last completed word, held until the next completion
//   strobe : one-cycle pulse in the cycle in which q is updated
//   busy   : a partial word is in progress (1..NR-1 chunks held)
// All outputs are registered.

module dechunker
  import chunk_pkg::*;
#(
  parameter int L = 8,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] d,
  input  logic         valid,
  input  logic         align,
  output logic [L-1:0] q,
  output logic         strobe,
  output logic         busy
);

  localparam int NR = L / M;
  localparam int CW = cnt_w(NR);
  localparam logic [CW-1:0] LAST = CW'(NR - 1);

  `CHUNK_WIDTH_CHECK(L, M)

  logic [L-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [L-1:0]  sh_in;
  logic          done;

  // The shifted value is also the completed word. sh is not cleared between
  // words because NR shifts fully overwrite it before the next completion.
  assign sh_in = {sh[L-M-1:0], d};

  always_comb begin
    cnt_nxt = cnt;
    done    = 1'b0;
    if (align) begin
      // A chunk that arrives with align starts the new word.
      cnt_nxt = '0;
      if (valid) begin
        if (NR == 1) done = 1'b1;
        else         cnt_nxt = CW'(1);
      end
    end else if (valid) begin
      if (cnt == LAST) begin
        done    = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh     <= '0;
      cnt    <= '0;
      q      <= '0;
      strobe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (valid) sh <= sh_in;
      cnt    <= cnt_nxt;
      busy   <= (cnt_nxt != '0);   // kept in step with cnt, not decoded from it
      strobe <= done;
      if (done) q <= sh_in;
    end
  end

`ifndef SYNTHESIS
  // Back-to-back strobes are only possible when a single chunk makes a word.
  if (NR > 1) begin : g_strobe_gap
    a_no_double_strobe: assert property (@(posedge clk) disable iff (reset)
      strobe |=> !strobe);
  end
  a_idle_on_strobe: assert property (@(posedge clk) disable iff (reset)
    strobe |-> !busy);
`endif

endmodule

// File: tb/tb_dechunker.sv
module tb_dechunker;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  d;
  logic        valid, align;
  logic [7:0]  q;
  logic        strobe, busy;

  logic [3:0]  d2;
  logic        valid2, align2;
  logic [15:0] q2;
  logic        strobe2, busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dechunker #(.L(8), .M(2)) u_dut (
    .clk(clk), .reset(reset), .d(d), .valid(valid), .align(align),
    .q(q), .strobe(strobe), .busy(busy)
  );

  dechunker #(.L(16), .M(4)) u_dut16 (
    .clk(clk), .reset(reset), .d(d2), .valid(valid2), .align(align2),
    .q(q2), .strobe(strobe2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one 8-bit word MSB chunk first with 'gap' idle cycles between chunks,
  // checking strobe/busy after every edge and q on completion.
  task automatic send8(input logic [7:0] w, input int gap, input string tag);
    for (int k = 0; k < 4; k++) begin
      d = w[7-2*k -: 2];
      valid = 1'b1;
      tick();
      valid = 1'b0;
      d = 2'b00;
      if (k < 3) begin
        chk({tag, "_nostb"}, strobe, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk({tag, "_gapstb"}, strobe, 1'b0);
        end
      end else begin
        chk({tag, "_stb"}, strobe, 1'b1);
        chk({tag, "_q"}, q, w);
        chk({tag, "_idle"}, busy, 1'b0);
      end
    end
  endtask

  task automatic send16(input logic [15:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      d2 = w[15-4*k -: 4];
      valid2 = 1'b1;
      tick();
      valid2 = 1'b0;
      d2 = 4'h0;
      if (k < 3) begin
        chk("lb16_nostb", strobe2, 1'b0);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("lb16_gapstb", strobe2, 1'b0);
        end
      end else begin
        chk("lb16_stb", strobe2, 1'b1);
        chk("lb16_q", q2, w);
      end
    end
  endtask

  task automatic chunk8(input logic [1:0] c, input logic al);
    d = c; valid = 1'b1; align = al;
    tick();
    valid = 1'b0; align = 1'b0; d = 2'b00;
  endtask

  initial begin
    reset = 1'b1; d = '0; valid = 1'b0; align = 1'b0;
    d2 = '0; valid2 = 1'b0; align2 = 1'b0;
    tick(); tick();
    chk("rst_q", q, 8'h00);
    chk("rst_stb", strobe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_q16", q2, 16'h0000);
    reset = 1'b0;
    tick();
    chk("idle_stb", strobe, 1'b0);

    // 01,10,10,01 -> 8'b01101001
    send8(8'b01101001, 0, "basic");
    tick();
    chk("basic_stbclr", strobe, 1'b0);
    chk("basic_qhold", q, 8'h69);

    send8(8'h69, 1, "gap1");
    tick();
    send8(8'h69, 3, "gap3");
    tick();
    chk("gap3_stbclr", strobe, 1'b0);

    // back-to-back: strobes exactly four cycles apart
    send8(8'h69, 0, "b2b_a");
    send8(8'hA5, 0, "b2b_b");
    tick();
    chk("b2b_stbclr", strobe, 1'b0);

    // partial word 11,11 dropped by align carrying chunk 0 of a new word
    chunk8(2'b11, 1'b0);
    chunk8(2'b11, 1'b0);
    chunk8(2'b01, 1'b1);
    chk("align_nostb", strobe, 1'b0);
    chk("align_busy", busy, 1'b1);
    chk("align_qhold", q, 8'hA5);
    chunk8(2'b10, 1'b0);
    chunk8(2'b10, 1'b0);
    chk("align_nostb2", strobe, 1'b0);
    chunk8(2'b01, 1'b0);
    chk("align_stb", strobe, 1'b1);
    chk("align_q", q, 8'h69);

    // align alone clears the partial word without a strobe
    chunk8(2'b10, 1'b0);
    chunk8(2'b10, 1'b0);
    align = 1'b1;
    tick();
    align = 1'b0;
    chk("alno_busy", busy, 1'b0);
    chk("alno_stb", strobe, 1'b0);
    send8(8'h3C, 0, "alno");

    // reset mid-word
    chunk8(2'b11, 1'b0);
    chunk8(2'b00, 1'b0);
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_q", q, 8'h00);
    chk("mid_stb", strobe, 1'b0);
    chk("mid_busy0", busy, 1'b0);
    send8(8'hCC, 0, "post_rst");
    tick();
    chk("post_rst_qhold", q, 8'hCC);
    chk("post_rst_stbclr", strobe, 1'b0);

    // serialized random words, MSB chunk first, random gaps
    for (int i = 0; i < 200; i++) send8(8'($urandom), $urandom_range(0, 2), "lb8");
    for (int i = 0; i < 200; i++) send16(16'($urandom), $urandom_range(0, 2));
    tick();
    chk("lb16_stbclr", strobe2, 1'b0);
    chk("lb16_busy", busy2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dechunker.md
# dechunker

Receive-side counterpart of `chunker`. Collects a stream of M-bit chunks, delivered MSB-chunk first under a per-chunk `valid`, and reassembles them into one L-bit word. Completion is signalled by a one-cycle `strobe`. It sits at the far end of a narrow M-bit link, so `chunker` → link → `dechunker` returns the original L-bit words.

## Interface
Parameters:
- `L`, default 8: assembled word width in bits.
- `M`, default 2: chunk width in bits. L must be a multiple of M and M < L; elaboration fails otherwise.
- `NR`, default L/M: chunks per word. Derived; never overridden.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `d`  in  M: incoming chunk.
- `valid`  in  1: `d` carries a chunk this cycle.
- `align`  in  1: discard any partial word; the next chunk starts a new word.
- `q`  out  L: last completed word; held until the next completion.
- `strobe`  out  1: one-cycle pulse, `q` updated this cycle.
- `busy`  out  1: a partial word is in progress (1..NR-1 chunks held).

## Operation
- Internal state:
  - shift register `sh[L-1:0]`.
  - chunk counter `cnt`, range 0..NR-1, width $clog2(NR) (minimum 1).
- Accepting a chunk (`valid`=1 at a rising edge):
  - `sh <= {sh[L-M-1:0], d}`.
  - If `cnt` < NR-1: `cnt <= cnt+1`.
  - If `cnt` = NR-1: `q <= {sh[L-M-1:0], d}`, `strobe <= 1`, `cnt <= 0`.
- Chunk order: the first chunk of a word lands in `q[L-1 -: M]`; the k-th chunk (k = 0..NR-1) lands in `q[(NR-1-k)*M +: M]`.
- `strobe` is 0 in every cycle not immediately following a completing edge.
- Gaps are allowed: `valid` may drop for any number of cycles mid-word. `cnt` and `sh` hold, and there is no timeout.
- `busy` = (`cnt` != 0), registered consistently with `cnt`.
- `align`=1 at an edge:
  - `cnt <= 0`; the partial word is dropped.
  - `q` is unchanged and no `strobe` is issued.
  - If `valid`=1 on the same edge, that chunk is taken as chunk 0 of the new word: `sh` shifts and `cnt <= 1`.
  - If NR=1, the word completes immediately.
- Precedence: `reset` > `align` > normal accept.
- `reset`=1 at an edge: `q`=0, `strobe`=0, `busy`=0, `cnt`=0, `sh`=0. A partial word in flight is discarded.
- `d` is ignored when `valid`=0. `sh` is not cleared between words; stale bits are always fully overwritten before the next completion.

## Timing
- Latency: last chunk sampled at edge N → `strobe`=1 and new `q` visible from edge N until edge N+1.
- Throughput: one chunk per cycle sustained. Back-to-back words give a `strobe` every NR cycles with no bubble.
- `q`, `strobe` and `busy` are registered outputs only; no combinational path from inputs to outputs.
- Pairing with `chunker` (its `q`→`d`, `valid`→`valid`): `strobe` fires exactly NR cycles after the first chunk is accepted, with `q` equal to chunker's `data_in`.

## Structure
- Single flat module `dechunker`; no sub-module needed. The counter and shift register are a few lines each.
- Shared package `chunk_pkg`:
  - `function automatic int cnt_w(int nr)`, returning max(1, $clog2(nr)).
  - Elaboration-check macro for L % M == 0.
  - Both `chunker` and `dechunker` import the package so the two ends agree on width rules.
- Assertions inside the module, under synthesis translate_off:
  - `strobe` is never high two cycles in a row unless `valid` was high on both completing edges with NR=1.
  - `busy` = 0 whenever `strobe` = 1.

## Test plan
- L=8, M=2: chunks 01,10,10,01 on four consecutive cycles → one `strobe`, `q`=8'b01101001, `busy` high for 3 cycles then low.
- Same word with `valid` gaps of 0, 1 and 3 cycles between chunks → identical `q`; `strobe` one cycle after the 4th accepted chunk; no spurious strobes.
- Back-to-back 8'h69 then 8'hA5 (chunks 10,10,01,01) → strobes 4 cycles apart, `q` = 8'h69 then 8'hA5.
- Two chunks 11,11, then `align`=1 with `valid`=1 carrying `d`=01, then 10,10,01 → `q`=8'b01101001 and no strobe for the dropped partial word.
- `reset` asserted after 2 of 4 chunks → all outputs 0. The next 4 chunks 11,00,11,00 → `q`=8'hCC.
- Loopback with `chunker`, L=8/M=2 and L=16/M=4, 200 random words → every `strobe` delivers the word strobed into `chunker`, in order.
